// File: rtl/cpu6_dmem_resp_pkg.sv
// Shared types and constants for the cpu6 data-memory responder.
// Contents: load/store width encodings, byte-enable size, default depth,
// store-buffer state enum and the store-buffer payload struct.
package cpu6_dmem_resp_pkg;

  localparam int unsigned XLEN                 = 32;
  localparam int unsigned CPU6_DMEM_BE_SIZE    = 4;
  localparam int unsigned CPU6_DMEM_DEPTH_LOG2 = 12;

  // Load/store access width as driven by the core on lswidthM.
  localparam logic [1:0] CPU6_LSWIDTH_B = 2'b00;
  localparam logic [1:0] CPU6_LSWIDTH_H = 2'b01;
  localparam logic [1:0] CPU6_LSWIDTH_W = 2'b10;

  // Posted store buffer occupancy.
  typedef enum logic {
    SB_EMPTY = 1'b0,
    SB_FULL  = 1'b1
  } sb_state_e;

  // Byte lanes and lane-aligned data of one buffered store.
  typedef struct packed {
    logic [CPU6_DMEM_BE_SIZE-1:0] be;
    logic [XLEN-1:0]              data;
  } sb_payload_t;

endpackage

// File: rtl/cpu6_dmem_resp_if.sv
// MEM-stage load/store bus between the cpu6 core (master) and the data
// memory responder (slave).
//  dataaddrM/writedataM/memwriteM/memreadM/lswidthM : request, core -> dmem
//  readdata_rawM/sb_empty/misalign                 : response, dmem -> core
interface cpu6_dmem_resp_if;
  import cpu6_dmem_resp_pkg::*;

  logic [XLEN-1:0] dataaddrM;
  logic [XLEN-1:0] writedataM;
  logic            memwriteM;
  logic            memreadM;
  logic [1:0]      lswidthM;
  logic [XLEN-1:0] readdata_rawM;
  logic            sb_empty;
  logic            misalign;

  modport master (
    output dataaddrM, writedataM, memwriteM, memreadM, lswidthM,
    input  readdata_rawM, sb_empty, misalign
  );

  modport slave (
    input  dataaddrM, writedataM, memwriteM, memreadM, lswidthM,
    output readdata_rawM, sb_empty, misalign
  );

endinterface

// File: rtl/cpu6_dmem_lane.sv
// Byte-lane steering for one access (combinational).
//  addr[1:0], lswidth : access offset and width
//  wdata              : right-aligned store data
//  raw                : memory word for the read path
//  be, wdata_lane     : byte enables and store data moved to its lanes
//  rdata              : addressed byte/half/word of raw, right-aligned, upper bits zero
//  misalign           : misaligned W/H access (only with CPU6_DMEM_MISALIGN_EN)
// Build option CPU6_DMEM_MISALIGN_EN: report misalignment and use the raw
// byte offset; otherwise misalign is 0 and W/H offsets are forced aligned.
module cpu6_dmem_lane
  import cpu6_dmem_resp_pkg::*;
(
  input  logic [1:0]                   addr,
  input  logic [1:0]                   lswidth,
  input  logic [XLEN-1:0]              wdata,
  input  logic [XLEN-1:0]              raw,
  output logic [CPU6_DMEM_BE_SIZE-1:0] be,
  output logic [XLEN-1:0]              wdata_lane,
  output logic [XLEN-1:0]              rdata,
  output logic                         misalign
);

  logic [1:0]      off;
  logic [XLEN-1:0] mask;

  // Byte enables, read mask and lane offset per access width.
  always_comb begin
    be       = 4'b1111;
    mask     = '1;
    off      = 2'b00;
    misalign = 1'b0;
    case (lswidth)
      CPU6_LSWIDTH_H: begin
        be   = 4'b0011 << {addr[1], 1'b0};
        mask = 32'h0000_ffff;
      end
      CPU6_LSWIDTH_B: begin
        be   = 4'b0001 << addr;
        mask = 32'h0000_00ff;
      end
      default: ;
    endcase
`ifdef CPU6_DMEM_MISALIGN_EN
    off      = addr;
    misalign = ((lswidth == CPU6_LSWIDTH_H) && addr[0]) ||
               ((lswidth != CPU6_LSWIDTH_H) && (lswidth != CPU6_LSWIDTH_B) && (addr != 2'b00));
`else
    case (lswidth)
      CPU6_LSWIDTH_H: off = {addr[1], 1'b0};
      CPU6_LSWIDTH_B: off = addr;
      default:        off = 2'b00;
    endcase
`endif
  end

  assign wdata_lane = wdata << {off, 3'b000};
  assign rdata      = (raw >> {off, 3'b000}) & mask;

endmodule

// File: rtl/cpu6_dmem_resp.sv
// cpu6 data-memory responder: synchronous word array with a one-entry posted
// store buffer and load forwarding from that buffer.
//  clk   : array and buffer update on posedge (mid-way through the MEM cycle)
//  reset : asynchronous, active-high; clears buffer and read registers, not the array
//  bus   : cpu6_dmem_resp_if.slave (request in, readdata_rawM/sb_empty/misalign out)
// Build option CPU6_DMEM_MISALIGN_EN: flag misaligned accesses and drop
// misaligned stores (handled inside cpu6_dmem_lane).
module cpu6_dmem_resp
  import cpu6_dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = CPU6_DMEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu6_dmem_resp_if.slave       bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [XLEN-1:0]              mem [DEPTH];

  logic [DEPTH_LOG2-1:0]        widx;
  logic [CPU6_DMEM_BE_SIZE-1:0] req_be;
  logic [XLEN-1:0]              req_wdata;
  logic                         req_mis;
  logic                         store_ok;
  logic                         drain;

  sb_state_e                    sb_state;
  logic                         sb_valid;
  logic [DEPTH_LOG2-1:0]        sb_widx;
  sb_payload_t                  sb;

  logic [XLEN-1:0]              rd_q;
  logic [1:0]                   addr_q;
  logic [1:0]                   width_q;
  logic [DEPTH_LOG2-1:0]        rwidx_q;
  logic [XLEN-1:0]              merged;
  logic [XLEN-1:0]              rdata;

  // Address bits above the array index are ignored, so the array aliases.
  logic unused_addr;
  assign unused_addr = ^bus.dataaddrM[XLEN-1:DEPTH_LOG2+2];

  assign widx = bus.dataaddrM[DEPTH_LOG2+1:2];

  // Request-side lane steering.
  logic [XLEN-1:0] unused_req_rdata;
  cpu6_dmem_lane u_lane_req (
    .addr       (bus.dataaddrM[1:0]),
    .lswidth    (bus.lswidthM),
    .wdata      (bus.writedataM),
    .raw        ('0),
    .be         (req_be),
    .wdata_lane (req_wdata),
    .rdata      (unused_req_rdata),
    .misalign   (req_mis)
  );

  assign sb_valid = (sb_state == SB_FULL);
  assign store_ok = bus.memwriteM && !bus.memreadM && !req_mis;
  // The single array port belongs to a load; otherwise a pending store drains.
  assign drain    = sb_valid && !bus.memreadM;

  // Store-buffer FSM and load read registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_state <= SB_EMPTY;
      sb_widx  <= '0;
      sb       <= '0;
      rd_q     <= '0;
      addr_q   <= 2'b00;
      width_q  <= CPU6_LSWIDTH_B;
      rwidx_q  <= '0;
    end else begin
      if (bus.memreadM) begin
        rd_q    <= mem[widx];
        addr_q  <= bus.dataaddrM[1:0];
        width_q <= bus.lswidthM;
        rwidx_q <= widx;
      end
      case (sb_state)
        SB_EMPTY: begin
          if (store_ok) sb_state <= SB_FULL;
        end
        SB_FULL: begin
          if (!bus.memreadM && !store_ok) sb_state <= SB_EMPTY;
        end
        default: sb_state <= SB_EMPTY;
      endcase
      if (store_ok) begin
        sb_widx <= widx;
        sb.be   <= req_be;
        sb.data <= req_wdata;
      end
    end
  end

  // Array write port: drain the buffered store under its byte enables.
  always_ff @(posedge clk) begin
    if (drain) begin
      for (int k = 0; k < int'(CPU6_DMEM_BE_SIZE); k++) begin
        if (sb.be[k]) mem[sb_widx][8*k +: 8] <= sb.data[8*k +: 8];
      end
    end
  end

  // Forward pending store bytes over the array read of the same word.
  always_comb begin
    merged = rd_q;
    if (sb_valid && (sb_widx == rwidx_q)) begin
      for (int k = 0; k < int'(CPU6_DMEM_BE_SIZE); k++) begin
        if (sb.be[k]) merged[8*k +: 8] = sb.data[8*k +: 8];
      end
    end
  end

  // Read-side lane steering uses the offset/width captured with rd_q.
  logic [CPU6_DMEM_BE_SIZE-1:0] unused_rd_be;
  logic [XLEN-1:0]              unused_rd_wdata;
  logic                         unused_rd_mis;
  cpu6_dmem_lane u_lane_rd (
    .addr       (addr_q),
    .lswidth    (width_q),
    .wdata      ('0),
    .raw        (merged),
    .be         (unused_rd_be),
    .wdata_lane (unused_rd_wdata),
    .rdata      (rdata),
    .misalign   (unused_rd_mis)
  );

  assign bus.readdata_rawM = rdata;
  assign bus.sb_empty      = !sb_valid;
  assign bus.misalign      = (bus.memreadM || bus.memwriteM) && req_mis;

  a_no_rd_and_wr: assert property (@(posedge clk) disable iff (reset)
                                   !(bus.memreadM && bus.memwriteM));

endmodule

// File: tb/tb_cpu6_dmem_resp.sv
// Randomized self-checking bench for cpu6_dmem_resp against an
// architectural memory model with one pending-store slot.
module tb_cpu6_dmem_resp;
  import cpu6_dmem_resp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu6_dmem_resp_if bus();

  cpu6_dmem_resp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: committed words plus at most one not-yet-committed store.
  logic [31:0] mdl_mem [int];
  bit          pend_v;
  int          pend_w;
  logic [3:0]  pend_be;
  logic [31:0] pend_d;
  logic [31:0] init_val [32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] mdl_be(input logic [1:0] w, input logic [1:0] a);
    if (w == CPU6_LSWIDTH_B) return 4'b0001 << a;
    if (w == CPU6_LSWIDTH_H) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic int mdl_off(input logic [1:0] w, input logic [1:0] a);
`ifdef CPU6_DMEM_MISALIGN_EN
    return int'(a);
`else
    if (w == CPU6_LSWIDTH_B) return int'(a);
    if (w == CPU6_LSWIDTH_H) return a[1] ? 2 : 0;
    return 0;
`endif
  endfunction

  function automatic bit mdl_mis(input logic [1:0] w, input logic [1:0] a);
`ifdef CPU6_DMEM_MISALIGN_EN
    if (w == CPU6_LSWIDTH_W) return a != 2'b00;
    if (w == CPU6_LSWIDTH_H) return a[0];
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] mdl_mask(input logic [1:0] w);
    if (w == CPU6_LSWIDTH_B) return 32'h0000_00ff;
    if (w == CPU6_LSWIDTH_H) return 32'h0000_ffff;
    return 32'hffff_ffff;
  endfunction

  // Architectural value of a word: committed contents with the pending store applied.
  function automatic logic [31:0] mdl_view(input int w);
    logic [31:0] v;
    v = mdl_mem.exists(w) ? mdl_mem[w] : 32'h0;
    if (pend_v && pend_w == w)
      for (int k = 0; k < 4; k++) if (pend_be[k]) v[8*k +: 8] = pend_d[8*k +: 8];
    return v;
  endfunction

  function automatic void mdl_commit();
    if (pend_v) mdl_mem[pend_w] = mdl_view(pend_w);
    pend_v = 1'b0;
  endfunction

  // One MEM cycle: drive at negedge, check just after the posedge.
  task automatic op(input bit rd, input bit wr, input logic [1:0] w,
                    input logic [31:0] a, input logic [31:0] d);
    int          wi;
    bit          mis;
    logic [31:0] exp;
    @(negedge clk);
    bus.memreadM   = rd;
    bus.memwriteM  = wr;
    bus.lswidthM   = w;
    bus.dataaddrM  = a;
    bus.writedataM = d;
    @(posedge clk);
    #1;
    wi  = int'({20'h0, a[13:2]});
    mis = mdl_mis(w, a[1:0]);
    check_eq("misalign", 32'(bus.misalign), 32'((rd || wr) && mis));
    if (rd) begin
      exp = (mdl_view(wi) >> (8 * mdl_off(w, a[1:0]))) & mdl_mask(w);
      check_eq("readdata", bus.readdata_rawM, exp);
    end else if (wr) begin
      mdl_commit();
      if (!mis) begin
        pend_v  = 1'b1;
        pend_w  = wi;
        pend_be = mdl_be(w, a[1:0]);
        pend_d  = d << (8 * mdl_off(w, a[1:0]));
      end
    end else begin
      mdl_commit();
    end
    check_eq("sb_empty", 32'(bus.sb_empty), 32'(!pend_v));
  endtask

  task automatic idle();                          op(1'b0, 1'b0, CPU6_LSWIDTH_W, 32'h0, 32'h0); endtask
  task automatic sw(input logic [31:0] a, input logic [31:0] d); op(1'b0, 1'b1, CPU6_LSWIDTH_W, a, d); endtask
  task automatic sh(input logic [31:0] a, input logic [31:0] d); op(1'b0, 1'b1, CPU6_LSWIDTH_H, a, d); endtask
  task automatic sb(input logic [31:0] a, input logic [31:0] d); op(1'b0, 1'b1, CPU6_LSWIDTH_B, a, d); endtask
  task automatic lw(input logic [31:0] a);        op(1'b1, 1'b0, CPU6_LSWIDTH_W, a, 32'h0); endtask
  task automatic lb(input logic [31:0] a);        op(1'b1, 1'b0, CPU6_LSWIDTH_B, a, 32'h0); endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  w;
    int          r;

    bus.memreadM = 1'b0; bus.memwriteM = 1'b0; bus.lswidthM = CPU6_LSWIDTH_W;
    bus.dataaddrM = '0;  bus.writedataM = '0;
    pend_v = 1'b0; pend_w = 0; pend_be = '0; pend_d = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_readdata", bus.readdata_rawM, 32'h0);
    check_eq("reset_sb_empty", 32'(bus.sb_empty), 32'h1);
    @(negedge clk) reset = 1'b0;

    // Give words 0..31 known contents.
    for (int i = 0; i < 32; i++) begin
      init_val[i] = $urandom;
      sw(32'(i * 4), init_val[i]);
    end
    idle();

    // Reset while the buffer holds a store discards it.
    sw(32'h50, 32'h1234_5678);
    @(negedge clk);
    bus.memwriteM = 1'b0;
    #2 reset = 1'b1;
    #1;
    pend_v = 1'b0;
    check_eq("rst_full_sb_empty", 32'(bus.sb_empty), 32'h1);
    check_eq("rst_full_readdata", bus.readdata_rawM, 32'h0);
    @(negedge clk) reset = 1'b0;
    lw(32'h50);
    check_eq("rst_lost_store", bus.readdata_rawM, init_val[20]);

    // Store then load of the same word forwards with no extra latency.
    sw(32'h10, 32'hdead_beef);
    lw(32'h10);
    check_eq("fwd_word", bus.readdata_rawM, 32'hdead_beef);
    check_eq("fwd_sb_full", 32'(bus.sb_empty), 32'h0);
    idle();
    check_eq("idle_drains", 32'(bus.sb_empty), 32'h1);

    // Byte store merged into an existing word.
    sw(32'h20, 32'h1122_3344);
    idle();
    sb(32'h22, 32'h0000_00aa);
    lb(32'h22);
    check_eq("fwd_byte", bus.readdata_rawM, 32'h0000_00aa);
    idle();
    lw(32'h20);
    check_eq("byte_merged", bus.readdata_rawM, 32'h11aa_3344);

    // Back-to-back half stores to one word.
    sh(32'h32, 32'h0000_beef);
    sh(32'h30, 32'h0000_cafe);
    idle();
    lw(32'h30);
    check_eq("half_pair", bus.readdata_rawM, 32'hbeef_cafe);

    // Load of a different word than the buffered one: no forwarding.
    sw(32'h40, 32'h0bad_f00d);
    idle();
    sw(32'h44, 32'h4444_4444);
    lw(32'h40);
    check_eq("no_fwd", bus.readdata_rawM, 32'h0bad_f00d);
    check_eq("no_fwd_sb_full", 32'(bus.sb_empty), 32'h0);
    idle();

    // Misaligned word store.
    sw(32'h10, 32'h0102_0304);
    idle();
    sw(32'h13, 32'hcafe_f00d);
`ifdef CPU6_DMEM_MISALIGN_EN
    check_eq("mis_flag", 32'(bus.misalign), 32'h1);
`else
    check_eq("mis_flag", 32'(bus.misalign), 32'h0);
`endif
    idle();
    lw(32'h10);
`ifdef CPU6_DMEM_MISALIGN_EN
    check_eq("mis_store_dropped", bus.readdata_rawM, 32'h0102_0304);
`else
    check_eq("mis_store_aligned", bus.readdata_rawM, 32'hcafe_f00d);
`endif

    // Random mix over words 0..31 with random aliasing upper address bits.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      a = ($urandom & 32'hffff_c000) | 32'($urandom_range(0, 127));
      d = $urandom;
      case ($urandom_range(0, 2))
        0:       w = CPU6_LSWIDTH_B;
        1:       w = CPU6_LSWIDTH_H;
        default: w = CPU6_LSWIDTH_W;
      endcase
      if (r < 4)      op(1'b1, 1'b0, w, a, 32'h0);
      else if (r < 8) op(1'b0, 1'b1, w, a, d);
      else            idle();
    end

    // Final sweep of every word through the load path.
    idle();
    for (int i = 0; i < 32; i++) lw(32'(i * 4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
